// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM controller slice.
// Duty width, ramp FSM states and the default duty ceiling.
package pwm_pkg;

  localparam int unsigned DUTY_W = 32;

  // Ceiling for legal duty words; the PWM interrupt threshold reuses it.
  localparam int unsigned DUTY_MAX_DEFAULT = 990000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  // Direction needed to move cur toward tgt.
  function automatic ramp_state_t ramp_dir(
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] cur
  );
    if (tgt > cur) begin
      return RAMP_UP;
    end else if (tgt < cur) begin
      return RAMP_DOWN;
    end
    return IDLE;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// pwm_period_tick: free-running period counter with end-of-period pulse.
// Shared with the PWM controller so both count the same period.
module pwm_period_tick #(
  parameter int unsigned PERIOD_BITS = 20
) (
  input  logic Clk,
  input  logic Reset,
  output logic tick
);

  logic [PERIOD_BITS-1:0] cnt_q;
  logic [PERIOD_BITS-1:0] cnt_d;

  // Wrap naturally from all-ones back to zero.
  always_comb begin
    cnt_d = cnt_q + PERIOD_BITS'(1);
  end

  // Counter register, cleared by synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews DutyCycle toward a clamped target once per period.
// Optional PWM_RAMP_RETARGET_EN: accept new targets while ramping.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = 20,
  parameter int unsigned STEP        = 1000,
  parameter int unsigned DUTY_MAX    = DUTY_MAX_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] DutyCycle,
  output logic              ramp_busy,
  output logic              range_err,
  output logic              period_tick
);

  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);

  ramp_state_t       state_q;
  ramp_state_t       state_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] tgt_q;
  logic [DUTY_W-1:0] tgt_d;
  logic              rerr_q;
  logic              rerr_d;
  logic              busy_q;
  logic              busy_d;

  logic              tick;
  logic              xfer;
  logic              over;
  logic [DUTY_W-1:0] eff;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W-1:0] up_nxt;
  logic [DUTY_W-1:0] dn_gap;
  logic [DUTY_W-1:0] dn_nxt;

  pwm_period_tick #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .tick (tick)
  );

`ifdef PWM_RAMP_RETARGET_EN
  assign target_ready = Reset;
`else
  assign target_ready = Reset && (state_q == IDLE);
`endif

  assign xfer = target_valid && target_ready;

  // Clamp the request and precompute both slew candidates.
  always_comb begin
    over   = target_duty > MAX_V;
    eff    = over ? MAX_V : target_duty;
    up_sum = {1'b0, duty_q} + {1'b0, STEP_V};
    up_nxt = (up_sum >= {1'b0, tgt_q}) ? tgt_q
                                       : up_sum[DUTY_W-1:0];
    dn_gap = duty_q - tgt_q;
    dn_nxt = (dn_gap <= STEP_V) ? tgt_q : duty_q - STEP_V;
  end

  // Next state: a transfer wins and suppresses the step on that tick.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    rerr_d  = rerr_q;
    if (xfer) begin
      tgt_d   = eff;
      rerr_d  = over;
      state_d = ramp_dir(eff, duty_q);
    end else if (tick) begin
      unique case (state_q)
        RAMP_UP: begin
          duty_d = up_nxt;
          if (up_nxt == tgt_q) begin
            state_d = IDLE;
          end
        end
        RAMP_DOWN: begin
          duty_d = dn_nxt;
          if (dn_nxt == tgt_q) begin
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // FSM and registered outputs; reset abandons any ramp at once.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      rerr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      rerr_q  <= rerr_d;
      busy_q  <= busy_d;
    end
  end

  assign DutyCycle   = duty_q;
  assign ramp_busy   = busy_q;
  assign range_err   = rerr_q;
  assign period_tick = tick;

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Upstream stage of the PWM controller. Accepts a target duty-cycle word from the PS over a valid/ready handshake. Slews its DutyCycle output toward that target in fixed steps, changing only at PWM period boundaries. Clamps out-of-range requests and flags them, so the downstream PWM never sees an invalid duty or a step change in mid-period.

Parameters:
PERIOD_BITS, 20, width of the internal period counter; must equal the PWM controller's period counter width so period boundaries align.
STEP, 1000, maximum duty change applied per period tick.
DUTY_MAX, 990000, largest legal duty value; larger requests are clamped to it.

Ports:
Clk  input  1  system clock, shared with the PWM controller.
Reset  input  1  synchronous, active-low reset.
target_duty  input  32  requested duty value.
target_valid  input  1  target_duty is valid this cycle.
target_ready  output  1  block can accept a target this cycle.
DutyCycle  output  32  registered duty value; feeds the PWM controller's DutyCycle input.
ramp_busy  output  1  high while the output is slewing.
range_err  output  1  sticky flag: the last accepted request exceeded DUTY_MAX.
period_tick  output  1  one-cycle pulse on the last count of each PWM period.

Behaviour:
- Clk is the only clock. Reset is synchronous and active-low.
- Reset (Reset==0 at a Clk edge) sets:
  - period counter = 0, state = IDLE, DutyCycle = 0, target register = 0;
  - range_err = 0, ramp_busy = 0, period_tick = 0.
  - target_ready = 0 while Reset is low. Reset mid-ramp abandons the ramp immediately.
- Period counter: free-running, PERIOD_BITS wide, wraps 2^PERIOD_BITS-1 -> 0.
  - period_tick is high in the cycle the counter equals 2^PERIOD_BITS-1.
  - Therefore a DutyCycle update lands exactly when the PWM count restarts at 0.
- target_ready = Reset && (state==IDLE). A transfer occurs when target_valid && target_ready. target_valid while not ready is ignored, not queued.
- On a transfer:
  - eff = (target_duty > DUTY_MAX) ? DUTY_MAX : target_duty;
  - range_err <= (target_duty > DUTY_MAX); the flag holds until the next transfer.
  - If eff == DutyCycle: stay IDLE, no output change.
  - If eff > DutyCycle: go to RAMP_UP. If eff < DutyCycle: go to RAMP_DOWN.
  - The target register is loaded with eff.
- RAMP_UP, on period_tick: DutyCycle <= min(DutyCycle+STEP, target). Compute with a 33-bit sum, no wrap. When the result equals target, go to IDLE.
- RAMP_DOWN, on period_tick: DutyCycle <= (DutyCycle-target <= STEP) ? target : DutyCycle-STEP. No underflow. When the result equals target, go to IDLE.
- DutyCycle changes only on period_tick cycles, except at reset.
- ramp_busy = (state != IDLE).
- A transfer in the same cycle as period_tick: the ramp starts from the next tick; no step is taken this cycle.
- Latency: first step at the first period_tick after the transfer cycle. Number of ticks to reach target = ceil(|eff-DutyCycle|/STEP).
- FSM summary:
  - IDLE -> RAMP_UP / RAMP_DOWN on transfer.
  - RAMP_x -> IDLE when target is reached.
  - No other transitions except reset.

Optional Feature:
PWM_RAMP_RETARGET_EN:
- Defined: target_ready = Reset in every state. A transfer during a ramp replaces the target register (clamp and range_err rules unchanged). The direction is re-evaluated against the current DutyCycle: go to IDLE if equal, otherwise RAMP_UP or RAMP_DOWN.
- Undefined: behaviour exactly as above; ready only in IDLE.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W = 32;
  - ramp state enum {IDLE, RAMP_UP, RAMP_DOWN};
  - default DUTY_MAX constant, also used as the PWM interrupt threshold.
- One sub-module: pwm_period_tick, holding the period counter and tick generation. It is reusable by the PWM controller so the two counters share one definition.

Test Plan:
- PERIOD_BITS=4, STEP=100. After reset, send target 350 -> ready drops; DutyCycle goes 100, 200, 300, 350 at ticks 1-4 (cycles 15, 31, 47, 63 after transfer); then IDLE, ready=1, range_err=0.
- From 350, send target 0 -> DutyCycle 250, 150, 50, 0 on successive ticks; no underflow.
- Send target 2000000 -> range_err=1; ramp ends at 990000 and DutyCycle never exceeds it. A subsequent target 500 clears range_err.
- Send a target equal to the current DutyCycle -> accepted, ready stays 1, ramp_busy stays 0, DutyCycle unchanged.
- Drop Reset for one cycle mid-ramp -> next cycle DutyCycle=0, state IDLE, period_tick restarts 16 cycles later. Also assert target_valid during a ramp without the macro -> no transfer; the ramp completes to the original target.
- With PWM_RAMP_RETARGET_EN: ramping 0->1000, retarget to 150 at DutyCycle=300 -> direction reverses; next ticks give 200, 150, then IDLE.
